// File: rtl/add_pkg.sv
// rtl/add_pkg.sv - shared state encoding and nibble width for the nibble-serial adder
package add_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam int NIB_W = 4;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_RUN  = ST_RUN,
    S_DONE = ST_DONE
  } state_t;

endpackage

// File: rtl/Add_rca_4.sv
// rtl/Add_rca_4.sv - 4-bit ripple-carry adder stage
module Add_rca_4 (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic       c_i,
  output logic [3:0] s_o,
  output logic       c_o
);

  logic [4:0] c_chain;

  assign c_chain[0] = c_i;

  // One full adder per bit, carry rippling from bit 0 upward
  for (genvar i = 0; i < 4; i++) begin : g_fa
    assign s_o[i]       = a_i[i] ^ b_i[i] ^ c_chain[i];
    assign c_chain[i+1] = (a_i[i] & b_i[i]) | (c_chain[i] & (a_i[i] ^ b_i[i]));
  end

  assign c_o = c_chain[4];

endmodule

// File: rtl/add_seq_nib.sv
// rtl/add_seq_nib.sv - nibble-serial wide adder controller around a single Add_rca_4
module add_seq_nib
  import add_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             overflow
);

  localparam int NIB   = WIDTH / NIB_W;
  localparam int CNT_W = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NIB - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] op_a_q, op_a_d;
  logic [WIDTH-1:0] op_b_q, op_b_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             c_out_q, c_out_d;
  logic             ovf_q, ovf_d;

  logic [NIB_W-1:0] rca_a, rca_b, rca_s;
  logic             rca_c;

  assign rca_a = op_a_q[NIB_W*count_q +: NIB_W];
  assign rca_b = op_b_q[NIB_W*count_q +: NIB_W];

  Add_rca_4 u_rca (
    .a_i (rca_a),
    .b_i (rca_b),
    .c_i (carry_q),
    .s_o (rca_s),
    .c_o (rca_c)
  );

  // Next-state: accept in IDLE/DONE, fold one nibble per RUN cycle, publish on the last one
  always_comb begin
    state_d = state_q;
    op_a_d  = op_a_q;
    op_b_d  = op_b_q;
    acc_d   = acc_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    count_d = count_q;
    c_out_d = c_out_q;
    ovf_d   = ovf_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          op_a_d  = a;
          op_b_d  = b;
          carry_d = c_in;
          count_d = '0;
          acc_d   = '0;
          state_d = S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        acc_d[NIB_W*count_q +: NIB_W] = rca_s;
        carry_d = rca_c;
        if (count_q == LAST) begin
          // Results become visible only here, so no partial sum ever leaks out
          state_d = S_DONE;
          sum_d   = acc_d;
          c_out_d = rca_c;
          ovf_d   = (op_a_q[WIDTH-1] == op_b_q[WIDTH-1]) &&
                    (acc_d[WIDTH-1] != op_a_q[WIDTH-1]);
        end else begin
          count_d = count_q + CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset discards any in-flight operation
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      op_a_q  <= '0;
      op_b_q  <= '0;
      acc_q   <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      count_q <= '0;
      c_out_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_a_q  <= op_a_d;
      op_b_q  <= op_b_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      count_q <= count_d;
      c_out_q <= c_out_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy     = (state_q == S_RUN);
  assign done     = (state_q == S_DONE);
  assign sum      = sum_q;
  assign c_out    = c_out_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_add_seq_nib.sv
// tb/tb_add_seq_nib.sv - directed self-checking bench for add_seq_nib
module tb_add_seq_nib;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] a, b;
  logic        c_in;
  logic        busy, done;
  logic [15:0] sum;
  logic        c_out, overflow;

  int checks = 0;
  int errors = 0;

  add_seq_nib #(.WIDTH(16)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .a        (a),
    .b        (b),
    .c_in     (c_in),
    .busy     (busy),
    .done     (done),
    .sum      (sum),
    .c_out    (c_out),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  // Start one operation and wait for done; reports observations only
  task automatic do_op(input logic [15:0] ia, input logic [15:0] ib, input logic ic,
                       output int busy_n, output bit got_done);
    busy_n   = 0;
    got_done = 0;
    @(negedge clk);
    a = ia; b = ib; c_in = ic; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (done) begin
        got_done = 1;
        break;
      end
      if (busy) busy_n++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; a = '0; b = '0; c_in = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, done, sum, c_out, overflow} !== 20'h0) begin
      errors++;
      $display("FAIL reset_state busy=%b done=%b sum=%h c_out=%b ovf=%b required all zero",
               busy, done, sum, c_out, overflow);
    end
    reset = 1'b0;
  endtask

  task automatic test_basic();
    int bn; bit gd;
    do_op(16'h1234, 16'h4321, 1'b0, bn, gd);
    checks++;
    if (!gd || bn != 4) begin
      errors++;
      $display("FAIL basic_latency done=%0d busy_cycles=%0d required done=1 busy_cycles=4", gd, bn);
    end
    checks++;
    if ({sum, c_out, overflow} !== {16'h5555, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL basic_result sum=%h c=%b v=%b required 5555 0 0", sum, c_out, overflow);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL basic_done_pulse done=%b busy=%b required 0 0", done, busy);
    end
  endtask

  task automatic test_carry();
    int bn; bit gd;
    do_op(16'hFFFF, 16'h0001, 1'b0, bn, gd);
    checks++;
    if (!gd || {sum, c_out, overflow} !== {16'h0000, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL carry_wrap done=%0d sum=%h c=%b v=%b required 0000 1 0", gd, sum, c_out, overflow);
    end
    do_op(16'h0FFF, 16'h0000, 1'b1, bn, gd);
    checks++;
    if (!gd || {sum, c_out, overflow} !== {16'h1000, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL carry_cin done=%0d sum=%h c=%b v=%b required 1000 0 0", gd, sum, c_out, overflow);
    end
  endtask

  task automatic test_overflow();
    int bn; bit gd;
    do_op(16'h7FFF, 16'h0001, 1'b0, bn, gd);
    checks++;
    if (!gd || {sum, c_out, overflow} !== {16'h8000, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL ovf_pos done=%0d sum=%h c=%b v=%b required 8000 0 1", gd, sum, c_out, overflow);
    end
    do_op(16'h8000, 16'h8000, 1'b0, bn, gd);
    checks++;
    if (!gd || {sum, c_out, overflow} !== {16'h0000, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL ovf_neg done=%0d sum=%h c=%b v=%b required 0000 1 1", gd, sum, c_out, overflow);
    end
  endtask

  task automatic test_busy_isolation();
    int dones = 0;
    bit gd = 0;
    @(negedge clk);
    a = 16'h1111; b = 16'h2222; c_in = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    // second RUN cycle: disturb inputs and pulse start
    @(negedge clk);
    checks++;
    if (sum !== 16'h0000) begin
      errors++;
      $display("FAIL iso_sum_hold sum=%h required 0000", sum);
    end
    a = 16'hFFFF; b = 16'hFFFF; c_in = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (done) begin gd = 1; break; end
      @(negedge clk);
    end
    checks++;
    if (!gd || sum !== 16'h3333 || c_out !== 1'b0) begin
      errors++;
      $display("FAIL iso_result done=%0d sum=%h c=%b required 3333 0", gd, sum, c_out);
    end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done || busy) dones++;
    end
    checks++;
    if (dones != 0) begin
      errors++;
      $display("FAIL iso_no_second_op active_cycles=%0d required 0", dones);
    end
  endtask

  task automatic test_back_to_back();
    int gap = 0;
    bit gd1 = 0, gd2 = 0;
    @(negedge clk);
    a = 16'h0001; b = 16'h0001; c_in = 1'b0; start = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      if (done) begin gd1 = 1; break; end
      @(negedge clk);
    end
    checks++;
    if (!gd1 || sum !== 16'h0002) begin
      errors++;
      $display("FAIL b2b_first done=%0d sum=%h required 0002", gd1, sum);
    end
    a = 16'h0002; b = 16'h0002;
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      if (done) begin gd2 = 1; break; end
      if (busy) gap++;
      @(negedge clk);
    end
    start = 1'b0;
    checks++;
    if (!gd2 || gap != 4 || sum !== 16'h0004) begin
      errors++;
      $display("FAIL b2b_second done=%0d run_cycles_between=%0d sum=%h required 1 4 0004", gd2, gap, sum);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL b2b_idle busy=%b done=%b required 0 0", busy, done);
    end
  endtask

  task automatic test_reset_mid_op();
    int bn; bit gd;
    int spurious = 0;
    do_op(16'hFFFF, 16'hFFFF, 1'b1, bn, gd);
    checks++;
    if (!gd || {sum, c_out, overflow} !== {16'hFFFF, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL rst_pre done=%0d sum=%h c=%b v=%b required FFFF 1 0", gd, sum, c_out, overflow);
    end
    @(negedge clk);
    a = 16'h1234; b = 16'h1111; c_in = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if ({busy, done, sum, c_out, overflow} !== 20'h0) begin
      errors++;
      $display("FAIL rst_mid busy=%b done=%b sum=%h c=%b v=%b required all zero",
               busy, done, sum, c_out, overflow);
    end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done || busy) spurious++;
    end
    checks++;
    if (spurious != 0) begin
      errors++;
      $display("FAIL rst_no_done active_cycles=%0d required 0", spurious);
    end
    do_op(16'h00FF, 16'h0F01, 1'b0, bn, gd);
    checks++;
    if (!gd || bn != 4 || {sum, c_out, overflow} !== {16'h1000, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL rst_fresh done=%0d busy_cycles=%0d sum=%h c=%b v=%b required 1 4 1000 0 0",
               gd, bn, sum, c_out, overflow);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_carry();
    test_overflow();
    test_busy_isolation();
    test_back_to_back();
    test_reset_mid_op();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
